// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache refill controller slice.
package cache_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    WR_CACHE,
    WR_MEM
  } ctrl_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// CPU request/response, cache array and backing memory buses of the refill controller.
interface cache_refill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  cache_read_en;
  logic                  cache_write_en;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  cache_hit;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  // The controller is the master of the cache and memory buses and serves the CPU.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data,
    output cache_read_en, cache_write_en, cache_addr, cache_wdata,
    input  cache_rdata, cache_hit,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data,
    input  cache_read_en, cache_write_en, cache_addr, cache_wdata,
    output cache_rdata, cache_hit,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/cache_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module cache_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Request controller in front of a direct-mapped cache array: lookup, read-miss refill,
// write-through stores and saturating hit/miss statistics.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_refill_ctrl_if.master  bus,
  output logic [CNT_WIDTH-1:0] stat_hits,
  output logic [CNT_WIDTH-1:0] stat_misses
);

  ctrl_state_e           state;
  ctrl_state_e           state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  accept;
  logic                  hit_event;
  logic                  miss_event;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign hit_event  = (state == CHECK) && bus.cache_hit;
  assign miss_event = (state == CHECK) && !bus.cache_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (bus.req_valid) state_next = bus.req_we ? WR_CACHE : LOOKUP;
      LOOKUP:   state_next = CHECK;
      CHECK:    state_next = bus.cache_hit ? IDLE : MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (bus.mem_rsp_valid) state_next = FILL;
      FILL:     state_next = IDLE;
      WR_CACHE: state_next = WR_MEM;
      WR_MEM:   if (bus.mem_req_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.cache_read_en  = 1'b0;
    bus.cache_write_en = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    unique case (state)
      IDLE:           bus.req_ready = 1'b1;
      LOOKUP:         bus.cache_read_en = 1'b1;
      FILL, WR_CACHE: bus.cache_write_en = 1'b1;
      MEM_REQ:        bus.mem_req_valid = 1'b1;
      WR_MEM: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // data_q holds the store data for writes and is reused for the refill line on read misses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept) begin
        addr_q <= bus.req_addr;
        data_q <= bus.req_wdata;
      end
      if ((state == MEM_WAIT) && bus.mem_rsp_valid) begin
        data_q <= bus.mem_rsp_data;
      end
      unique case (state)
        CHECK: begin
          if (bus.cache_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.cache_rdata;
          end
        end
        FILL: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= data_q;
        end
        WR_MEM: begin
          if (bus.mem_req_ready) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.cache_addr    = addr_q;
  assign bus.cache_wdata   = data_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = data_q;

  cache_sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_event),
    .count (stat_hits)
  );

  cache_sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_event),
    .count (stat_misses)
  );

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios plus random traffic against a
// request-level model of a write-allocate, write-through direct-mapped cache.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int AW      = ADDR_WIDTH_DEF;
  localparam int DW      = DATA_WIDTH_DEF;
  localparam int CW      = 2;
  localparam int LINES   = 64;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] stat_hits;
  logic [CW-1:0] stat_misses;

  cache_refill_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // 1 KiB direct-mapped array of 16-byte lines: index addr[9:4], tag addr[31:10].
  logic [DW-1:0] arr_data  [LINES];
  logic [21:0]   arr_tag   [LINES];
  bit            arr_valid [LINES];

  logic [DW-1:0] back_mem [logic [AW-1:0]];
  int            stall_cfg = 0, mem_latency = 1, stall_left = 0, rsp_countdown = 0;
  bit            stray_rsp = 1'b0;
  logic [DW-1:0] rsp_pending;
  bit            prev_valid = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  int            mem_reads = 0, mem_writes = 0, proto_errors = 0;
  logic [AW-1:0] last_mem_rd_addr, last_mem_wr_addr;
  logic [DW-1:0] last_mem_wr_data;

  int            rsp_pulses = 0, cache_wr_cycles = 0, cache_rd_cycles = 0, mem_valid_cycles = 0;
  logic [AW-1:0] last_cache_waddr;
  logic [DW-1:0] last_cache_wdata;

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            ref_valid [LINES];
  logic [21:0]   ref_tag   [LINES];
  int            ref_hits = 0, ref_misses = 0;

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0FF_EE00};
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  initial begin
    bus.cache_rdata = '0;
    bus.cache_hit   = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.cache_read_en) begin
        bus.cache_rdata <= arr_data[bus.cache_addr[9:4]];
        bus.cache_hit   <= arr_valid[bus.cache_addr[9:4]] &&
                           (arr_tag[bus.cache_addr[9:4]] == bus.cache_addr[31:10]);
      end
      if (bus.cache_write_en) begin
        arr_data[bus.cache_addr[9:4]]  <= bus.cache_wdata;
        arr_tag[bus.cache_addr[9:4]]   <= bus.cache_addr[31:10];
        arr_valid[bus.cache_addr[9:4]] <= 1'b1;
      end
    end
  end

  // Backing memory: programmable stall before ready, fixed read latency, random stray strobes.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_valid && prev_ready) begin
        if (prev_we) begin
          back_mem[prev_addr] = prev_wdata;
          mem_writes++;
          last_mem_wr_addr = prev_addr;
          last_mem_wr_data = prev_wdata;
        end else begin
          rsp_pending   = back_mem.exists(prev_addr) ? back_mem[prev_addr] : mem_init(prev_addr);
          rsp_countdown = mem_latency;
          mem_reads++;
          last_mem_rd_addr = prev_addr;
        end
      end else if (prev_valid && !reset) begin
        if (!(bus.mem_req_valid && (bus.mem_req_we == prev_we) &&
              (bus.mem_req_addr == prev_addr) && (bus.mem_req_wdata == prev_wdata))) begin
          proto_errors++;
        end
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      if (rsp_countdown > 0) begin
        rsp_countdown--;
        if (rsp_countdown == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = rsp_pending;
        end
      end
      if ((rsp_countdown == 0) && !bus.mem_rsp_valid && (stray_rsp || ($urandom_range(0, 7) == 0))) begin
        bus.mem_rsp_valid = 1'b1;
        stray_rsp         = 1'b0;
      end
      if (!bus.mem_req_valid) begin
        stall_left        = stall_cfg;
        bus.mem_req_ready = 1'($urandom_range(0, 1));
      end else if (stall_left > 0) begin
        stall_left--;
        bus.mem_req_ready = 1'b0;
      end else begin
        bus.mem_req_ready = 1'b1;
      end
      prev_valid = bus.mem_req_valid;
      prev_ready = bus.mem_req_ready;
      prev_we    = bus.mem_req_we;
      prev_addr  = bus.mem_req_addr;
      prev_wdata = bus.mem_req_wdata;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      rsp_pulses       += int'(bus.rsp_valid);
      cache_rd_cycles  += int'(bus.cache_read_en);
      mem_valid_cycles += int'(bus.mem_req_valid);
      if (bus.cache_write_en) begin
        cache_wr_cycles++;
        last_cache_waddr = bus.cache_addr;
        last_cache_wdata = bus.cache_wdata;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    checkOutput({pfx, "/req_ready"}, bus.req_ready, 1);
    checkOutput({pfx, "/rsp_valid"}, bus.rsp_valid, 0);
    checkOutput({pfx, "/rsp_data"}, bus.rsp_data, 0);
    checkOutput({pfx, "/cache_read_en"}, bus.cache_read_en, 0);
    checkOutput({pfx, "/cache_write_en"}, bus.cache_write_en, 0);
    checkOutput({pfx, "/cache_addr"}, bus.cache_addr, 0);
    checkOutput({pfx, "/cache_wdata"}, bus.cache_wdata, 0);
    checkOutput({pfx, "/mem_req_valid"}, bus.mem_req_valid, 0);
    checkOutput({pfx, "/mem_req_we"}, bus.mem_req_we, 0);
    checkOutput({pfx, "/mem_req_addr"}, bus.mem_req_addr, 0);
    checkOutput({pfx, "/mem_req_wdata"}, bus.mem_req_wdata, 0);
    checkOutput({pfx, "/stat_hits"}, stat_hits, 0);
    checkOutput({pfx, "/stat_misses"}, stat_misses, 0);
  endtask

  // Issues one request, then keeps a junk request pending while busy to prove it is not taken.
  task automatic applyStimulus(input string name, input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, output int lat,
                               output logic [DW-1:0] data, output bit got);
    int n;
    n = 0;
    while (!bus.req_ready && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "/ready_before_accept"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    checkOutput({name, "/ready_while_busy"}, bus.req_ready, 0);
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    lat  = 0;
    got  = 1'b0;
    data = '0;
    while (!got && (lat < 60)) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) begin
        got           = 1'b1;
        data          = bus.rsp_data;
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic run_request(input string name, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int stall, input int lat);
    logic [5:0]    idx;
    logic [21:0]   tag;
    bit            exp_hit, got;
    logic [DW-1:0] exp_data, exp_fill, obs_data;
    int            exp_lat, obs_lat;
    int            s_rsp, s_wr, s_rd, s_mv, s_pe, s_mr, s_mw;
    idx      = addr[9:4];
    tag      = addr[31:10];
    exp_hit  = !we && ref_valid[idx] && (ref_tag[idx] == tag);
    exp_data = we ? '0 : ref_read(addr);
    exp_fill = we ? wdata : exp_data;
    exp_lat  = we ? 2 + stall : (exp_hit ? 2 : 4 + stall + lat);
    if (we) ref_mem[addr] = wdata;
    if (!exp_hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
    end
    if (!we) begin
      if (exp_hit) ref_hits = sat_inc(ref_hits);
      else         ref_misses = sat_inc(ref_misses);
    end
    stall_cfg   = stall;
    mem_latency = lat;
    s_rsp = rsp_pulses;   s_wr = cache_wr_cycles; s_rd = cache_rd_cycles;
    s_mv  = mem_valid_cycles; s_pe = proto_errors; s_mr = mem_reads; s_mw = mem_writes;
    applyStimulus(name, we, addr, wdata, obs_lat, obs_data, got);
    @(posedge clk);
    #1;
    checkOutput({name, "/rsp_seen"}, got, 1);
    checkOutput({name, "/rsp_data"}, obs_data, exp_data);
    checkOutput({name, "/latency"}, obs_lat, exp_lat);
    checkOutput({name, "/rsp_pulses"}, rsp_pulses - s_rsp, 1);
    checkOutput({name, "/cache_reads"}, cache_rd_cycles - s_rd, we ? 0 : 1);
    checkOutput({name, "/cache_writes"}, cache_wr_cycles - s_wr, exp_hit ? 0 : 1);
    if (!exp_hit) begin
      checkOutput({name, "/cache_waddr"}, last_cache_waddr, addr);
      checkOutput({name, "/cache_wdata"}, last_cache_wdata, exp_fill);
    end
    checkOutput({name, "/mem_valid_cycles"}, mem_valid_cycles - s_mv, exp_hit ? 0 : stall + 1);
    checkOutput({name, "/mem_reads"}, mem_reads - s_mr, (!we && !exp_hit) ? 1 : 0);
    checkOutput({name, "/mem_writes"}, mem_writes - s_mw, we ? 1 : 0);
    if (we) begin
      checkOutput({name, "/mem_wr_addr"}, last_mem_wr_addr, addr);
      checkOutput({name, "/mem_wr_data"}, last_mem_wr_data, wdata);
    end else if (!exp_hit) begin
      checkOutput({name, "/mem_rd_addr"}, last_mem_rd_addr, addr);
    end
    checkOutput({name, "/mem_req_stable"}, proto_errors - s_pe, 0);
    checkOutput({name, "/stat_hits"}, stat_hits, ref_hits);
    checkOutput({name, "/stat_misses"}, stat_misses, ref_misses);
    checkOutput({name, "/ready_after"}, bus.req_ready, 1);
  endtask

  bit            rnd_we;
  logic [AW-1:0] rnd_addr;
  logic [DW-1:0] rnd_wdata;
  int            n_wait, reads_before, rsp_before, wr_before;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_request("t1_write", 1'b1, 32'h10, 128'hA5A5, 0, 1);
    run_request("t2_read_hit", 1'b0, 32'h10, '0, 0, 1);
    back_mem[32'h20] = 128'hDEAD;
    ref_mem[32'h20]  = 128'hDEAD;
    run_request("t3_cold_read", 1'b0, 32'h20, '0, 3, 2);
    run_request("t3_reread", 1'b0, 32'h20, '0, 0, 1);
    run_request("t4_alias", 1'b0, 32'h420, '0, 1, 1);
    run_request("t4_back", 1'b0, 32'h20, '0, 0, 3);

    for (int i = 0; i < 40; i++) begin
      rnd_we    = ($urandom_range(0, 2) == 0);
      rnd_addr  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4);
      rnd_wdata = {$urandom, $urandom, $urandom, $urandom};
      run_request($sformatf("rnd%0d", i), rnd_we, rnd_addr, rnd_wdata,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    // Reset while the controller waits for memory read data.
    stall_cfg     = 0;
    mem_latency   = 8;
    reads_before  = mem_reads;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h7050;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_wait = 0;
    while ((mem_reads == reads_before) && (n_wait < 20)) begin
      @(posedge clk);
      #2;
      n_wait++;
    end
    checkOutput("t5/reached_mem_wait", mem_reads - reads_before, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_reset");
    ref_hits   = 0;
    ref_misses = 0;
    @(negedge clk);
    reset      = 1'b0;
    rsp_before = rsp_pulses;
    wr_before  = cache_wr_cycles;
    stray_rsp  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t5/no_rsp_after_reset", rsp_pulses - rsp_before, 0);
    checkOutput("t5/no_fill_after_reset", cache_wr_cycles - wr_before, 0);
    checkOutput("t5/idle_after_reset", bus.req_ready, 1);

    for (int k = 0; k < 5; k++) begin
      run_request($sformatf("t6_miss%0d", k), 1'b0, (32'(28 + k) << 10) | 32'h50, '0, 0, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6/misses_saturated", stat_misses, 3);
    checkOutput("t6/hits_zero", stat_hits, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
